conv_outcome_gather: RTL and testbench

Streaming collector between the sliding-window convolution engine and the pooling/writeback stage. It takes one raw window result per input pixel in raster order and discards results whose window is not fully inside the image: warm-up rows, row-wrap columns, and positions off the stride grid. Valid results are buffered in a FIFO with valid/ready output, and the last output of each frame is tagged. It generalises the fixed 3-column, single-channel, free-running collector to parametrised image size, kernel, stride and channel count, and adds backpressure, frame tagging and reset.

---
 rtl/cnn_pkg.sv | 10 +
 rtl/outcome_fifo.sv | 35 +++
 rtl/conv_outcome_gather.sv | 91 +++++++++
 tb/tb_conv_outcome_gather.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared output-grid sizing and result beat layout for the CNN streaming blocks.
package cnn_pkg;
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction
  typedef struct packed {
    logic        last;
    logic [17:0] data;
  } result_beat;
endpackage

// File: rtl/outcome_fifo.sv
// outcome_fifo: synchronous power-of-two FIFO with wrap-bit pointers; read data is zero while empty.
module outcome_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign count = wptr - rptr;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/conv_outcome_gather.sv
// conv_outcome_gather: keeps only fully-inside, on-stride window results and buffers them with a frame-last tag.
module conv_outcome_gather
  import cnn_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int CH         = 1,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int STRIDE     = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  input  logic [CH*WIDTH-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CH*WIDTH-1:0]   m_data,
  output logic                  m_last,
  output logic                  frame_done
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int PW = STRIDE > 1 ? $clog2(STRIDE) : 1;
  localparam int OW = out_dim(IMG_W, K, STRIDE);
  localparam int OH = out_dim(IMG_H, K, STRIDE);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_START = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(K - 1 + (OW - 1) * STRIDE);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_START = RW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1 + (OH - 1) * STRIDE);
  localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);
  typedef struct packed {
    logic                last;
    logic [CH*WIDTH-1:0] data;
  } beat_t;
  logic [CW-1:0] col, c;
  logic [RW-1:0] row, r;
  logic [PW-1:0] cphase, rphase, cp, rp;
  logic accept, keep, col_wrap, frame_end, full, empty;
  beat_t in_beat, out_beat;
  // A start-of-frame beat is evaluated as pixel (0,0) regardless of the counters.
  always_comb begin
    c         = s_sof ? '0 : col;
    r         = s_sof ? '0 : row;
    cp        = s_sof ? '0 : cphase;
    rp        = s_sof ? '0 : rphase;
    accept    = s_valid && s_ready;
    col_wrap  = c == COL_MAX;
    frame_end = col_wrap && r == ROW_MAX;
    keep      = r >= ROW_START && c >= COL_START && rp == '0 && cp == '0;
    in_beat.last = r == ROW_LAST && c == COL_LAST;
    in_beat.data = s_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      cphase     <= '0;
      rphase     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && frame_end;
      if (accept) begin
        col    <= col_wrap ? '0 : c + 1'b1;
        cphase <= (col_wrap || c < COL_START || cp == PH_MAX) ? '0 : cp + 1'b1;
        row    <= col_wrap ? (frame_end ? '0 : r + 1'b1) : r;
        rphase <= col_wrap ? ((frame_end || r < ROW_START || rp == PH_MAX) ? '0 : rp + 1'b1) : rp;
      end
    end
  end
  outcome_fifo #(.W(CH*WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && keep),
    .wdata (in_beat),
    .pop   (m_valid && m_ready),
    .rdata (out_beat),
    .full  (full),
    .empty (empty),
    .count ()
  );
  assign s_ready = !full;
  assign m_valid = !empty;
  assign m_data  = out_beat.data;
  assign m_last  = out_beat.last;
endmodule

// File: tb/tb_conv_outcome_gather.sv
// tb_conv_outcome_gather: scoreboard bench over three configurations (default, stride 2, 4-channel depth-4).
module tb_conv_outcome_gather;
  typedef struct {
    logic [71:0] d;
    bit          last;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
  logic [71:0] s_data = '0;
  int cur = 0;
  logic sr [3], mv [3], ml [3], fd [3];
  logic [17:0] md0, md1;
  logic [71:0] md2;
  logic o_sr, o_mv, o_ml, o_fd;
  logic [71:0] o_md;
  exp_t q [$];
  int got [$];
  int tests = 0, fails = 0;
  int mrow = 0, mcol = 0, kept = 0, lasts = 0, fdones = 0;
  int first_full_kept = -1, first_full_pix = -1;
  bit fd_exp = 0, hold = 0;
  logic [71:0] hd = '0;
  always #5 clk = ~clk;
  always_comb begin
    o_sr = sr[cur];
    o_mv = mv[cur];
    o_ml = ml[cur];
    o_fd = fd[cur];
    o_md = cur == 0 ? {54'b0, md0} : cur == 1 ? {54'b0, md1} : md2;
  end
  conv_outcome_gather u0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid && cur == 0), .s_ready(sr[0]), .s_sof(s_sof),
    .s_data(s_data[17:0]), .m_valid(mv[0]), .m_ready(m_ready), .m_data(md0), .m_last(ml[0]),
    .frame_done(fd[0]));
  conv_outcome_gather #(.STRIDE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid && cur == 1), .s_ready(sr[1]), .s_sof(s_sof),
    .s_data(s_data[17:0]), .m_valid(mv[1]), .m_ready(m_ready), .m_data(md1), .m_last(ml[1]),
    .frame_done(fd[1]));
  conv_outcome_gather #(.CH(4), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid && cur == 2), .s_ready(sr[2]), .s_sof(s_sof),
    .s_data(s_data), .m_valid(mv[2]), .m_ready(m_ready), .m_data(md2), .m_last(ml[2]),
    .frame_done(fd[2]));

  task automatic start(input int sel);
    cur = sel;
    q.delete();
    got.delete();
    mrow = 0;
    mcol = 0;
    kept = 0;
    lasts = 0;
    fdones = 0;
  endtask

  // Streams npix pixels on the selected instance while the scoreboard tracks keep/last/frame_done.
  task automatic run(input int npix, input bit sof, input int vpct, input int rpct, input int stall, input bit drain);
    int p = 0, cyc = 0;
    int s = cur == 1 ? 2 : 1;
    int lr = 2 + ((8 - 3) / s) * s;
    exp_t e;
    while ((p < npix || (drain && q.size() > 0)) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      tests++;
      if (o_fd !== fd_exp) begin
        fails++;
        $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, o_fd, fd_exp);
      end
      if (o_fd) fdones++;
      if (hold) begin
        tests++;
        if (o_mv !== 1'b1 || o_md !== hd) begin
          fails++;
          $display("FAIL hold got valid=%b data=%h exp valid=1 data=%h", o_mv, o_md, hd);
        end
      end
      if (!o_sr && first_full_kept < 0) begin
        first_full_kept = kept;
        first_full_pix = p;
      end
      s_valid = p < npix && int'($urandom_range(99)) < vpct;
      s_sof = sof && p == 0;
      s_data = cur == 2 ? 72'({$urandom(), $urandom(), $urandom()}) : 72'(p % 64);
      m_ready = cyc > stall && int'($urandom_range(99)) < rpct;
      if (o_mv && m_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_output got=%h exp=none", o_md);
        end else begin
          e = q.pop_front();
          tests++;
          if (o_md !== e.d || o_ml !== e.last) begin
            fails++;
            $display("FAIL output got=%h last=%b exp=%h last=%b", o_md, o_ml, e.d, e.last);
          end
          got.push_back(int'(o_md[17:0]));
          if (o_ml) lasts++;
        end
      end
      hold = o_mv && !m_ready;
      hd = o_md;
      fd_exp = 0;
      if (s_valid && o_sr) begin
        if (s_sof) begin
          mrow = 0;
          mcol = 0;
        end
        if (mrow >= 2 && mcol >= 2 && (mrow - 2) % s == 0 && (mcol - 2) % s == 0) begin
          e.d = cur == 2 ? s_data : {54'b0, s_data[17:0]};
          e.last = mrow == lr && mcol == lr;
          q.push_back(e);
          kept++;
        end
        fd_exp = mrow == 7 && mcol == 7;
        mcol++;
        if (mcol == 8) begin
          mcol = 0;
          mrow = mrow == 7 ? 0 : mrow + 1;
        end
        p++;
      end
    end
    if (cyc >= 5000) begin
      tests++;
      fails++;
      $display("FAIL timeout got pix=%0d pending=%0d exp pix=%0d pending=0", p, q.size(), npix);
    end
    @(negedge clk);
    tests++;
    if (o_fd !== fd_exp) begin
      fails++;
      $display("FAIL frame_done_tail got=%b exp=%b", o_fd, fd_exp);
    end
    if (o_fd) fdones++;
    fd_exp = 0;
    s_valid = 0;
    s_sof = 0;
    m_ready = 0;
    hold = o_mv;
    hd = o_md;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #0;
      tests++;
      if (o_sr !== 1'b1 || o_mv !== 1'b0 || o_md !== '0 || o_ml !== 1'b0 || o_fd !== 1'b0) begin
        fails++;
        $display("FAIL reset_values inst=%0d got rdy=%b v=%b d=%h l=%b fd=%b exp 1 0 0 0 0", i, o_sr, o_mv, o_md, o_ml, o_fd);
      end
    end
    rst_n = 1;
  endtask

  task automatic test_basic;
    start(0);
    run(64, 0, 100, 100, 0, 1);
    tests++;
    if (got.size() != 36 || got[0] != 18 || got[5] != 23 || got[6] != 26 || got[35] != 63) begin
      fails++;
      $display("FAIL basic_seq got n=%0d first=%0d g5=%0d g6=%0d end=%0d exp 36 18 23 26 63", got.size(), got[0], got[5], got[6], got[35]);
    end
    tests++;
    if (lasts != 1 || fdones != 1) begin
      fails++;
      $display("FAIL basic_tags got last=%0d fd=%0d exp 1 1", lasts, fdones);
    end
  endtask

  task automatic test_stride;
    int exp_s [9] = '{18, 20, 22, 34, 36, 38, 50, 52, 54};
    start(1);
    run(64, 0, 100, 100, 0, 1);
    tests++;
    if (got.size() != 9 || lasts != 1) begin
      fails++;
      $display("FAIL stride_count got n=%0d last=%0d exp 9 1", got.size(), lasts);
    end
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (got[i] != exp_s[i]) begin
        fails++;
        $display("FAIL stride_val[%0d] got=%0d exp=%0d", i, got[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    start(2);
    first_full_kept = -1;
    run(64, 0, 100, 100, 40, 1);
    tests++;
    if (first_full_kept != 4 || first_full_pix != 22) begin
      fails++;
      $display("FAIL full_point got kept=%0d pix=%0d exp 4 22", first_full_kept, first_full_pix);
    end
    tests++;
    if (got.size() != 36 || lasts != 1) begin
      fails++;
      $display("FAIL bp_count got n=%0d last=%0d exp 36 1", got.size(), lasts);
    end
  endtask

  task automatic test_mid_reset;
    start(0);
    run(30, 0, 100, 0, 0, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    tests++;
    if (o_sr !== 1'b1 || o_mv !== 1'b0 || o_md !== '0 || o_ml !== 1'b0 || o_fd !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got rdy=%b v=%b d=%h l=%b fd=%b exp 1 0 0 0 0", o_sr, o_mv, o_md, o_ml, o_fd);
    end
    hold = 0;
    start(0);
    run(64, 0, 100, 100, 0, 1);
    tests++;
    if (got.size() != 36 || got[0] != 18 || got[35] != 63 || lasts != 1) begin
      fails++;
      $display("FAIL post_reset got n=%0d first=%0d end=%0d last=%0d exp 36 18 63 1", got.size(), got[0], got[35], lasts);
    end
  endtask

  task automatic test_sof;
    start(0);
    run(40, 0, 100, 100, 0, 0);
    run(64, 1, 100, 100, 0, 1);
    tests++;
    if (got.size() != 54 || got[17] != 39 || got[18] != 18 || got[53] != 63 || lasts != 1) begin
      fails++;
      $display("FAIL sof_seq got n=%0d g17=%0d g18=%0d end=%0d last=%0d exp 54 39 18 63 1", got.size(), got[17], got[18], got[53], lasts);
    end
  endtask

  task automatic test_random;
    start(2);
    run(192, 1, 50, 50, 0, 1);
    tests++;
    if (lasts != 3 || fdones != 3 || got.size() != 108) begin
      fails++;
      $display("FAIL random_frames got last=%0d fd=%0d n=%0d exp 3 3 108", lasts, fdones, got.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_backpressure();
    test_mid_reset();
    test_sof();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
